// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with an occupancy counter, programmable almost-full and
// almost-empty levels, and sticky overrun/underrun flags that software clears.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_enb,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_enb,
  output logic [DATA_WIDTH-1:0]    rd_data,
  input  logic                     err_clr,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     fifo_almost_full,
  output logic                     fifo_almost_empty,
  output logic                     fifo_overrun,
  output logic                     fifo_underrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two and at least 2");
  end
  if (AE_LEVEL < 1 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH - 1) begin : g_bad_levels
    $error("fifo_sync_param: need 1 <= AE_LEVEL < AF_LEVEL <= DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  overrun_set;
  logic                  underrun_set;

  // Every level flag is a pure decode of the counter, so they can never disagree.
  assign fifo_count        = count;
  assign fifo_full         = (count == CNT_W'(DEPTH));
  assign fifo_empty        = (count == '0);
  assign fifo_almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign fifo_almost_empty = (count <= CNT_W'(AE_LEVEL));

  // A read in the same cycle frees a slot, so a full FIFO still takes the write.
  assign rd_ok        = rd_enb & ~fifo_empty;
  assign wr_ok        = wr_enb & (~fifo_full | rd_enb);
  assign overrun_set  = wr_enb & fifo_full & ~rd_enb;
  assign underrun_set = rd_enb & fifo_empty;

  // NOTE: storage has no reset; pointers and count define what is valid, and a
  // resettable array would cost a reset net on every bit for no functional gain.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a new error in the clearing cycle takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_overrun  <= 1'b0;
      fifo_underrun <= 1'b0;
    end else begin
      fifo_overrun  <= overrun_set  | (fifo_overrun  & ~err_clr);
      fifo_underrun <= underrun_set | (fifo_underrun & ~err_clr);
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 1;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_enb = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_enb = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] rd_data;
  logic [3:0]    fifo_count;
  logic          fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic          fifo_overrun, fifo_underrun;

  fifo_sync_param #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_data(wr_data),
    .rd_enb(rd_enb), .rd_data(rd_data), .err_clr(err_clr),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_almost_full(fifo_almost_full), .fifo_almost_empty(fifo_almost_empty),
    .fifo_overrun(fifo_overrun), .fifo_underrun(fifo_underrun)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: contents as a queue, plus last read word and sticky flags.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd_data = '0;
  logic          m_ovr = 1'b0;
  logic          m_und = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic w, input logic r, input logic [DW-1:0] d,
                            input logic c, input logic rs);
    int  n;
    bit  rd_acc, wr_acc;
    n = q.size();
    if (rs) begin
      q.delete();
      m_rd_data = '0;
      m_ovr = 1'b0;
      m_und = 1'b0;
    end else begin
      rd_acc = r && (n > 0);
      wr_acc = w && (n < DEPTH || r);
      m_ovr = (w && n == DEPTH && !r) || (m_ovr && !c);
      m_und = (r && n == 0) || (m_und && !c);
      if (rd_acc) m_rd_data = q.pop_front();
      if (wr_acc) q.push_back(d);
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    check("count",        32'(fifo_count),        32'(n));
    check("full",         32'(fifo_full),         32'(n == DEPTH));
    check("empty",        32'(fifo_empty),        32'(n == 0));
    check("almost_full",  32'(fifo_almost_full),  32'(n >= AF));
    check("almost_empty", 32'(fifo_almost_empty), 32'(n <= AE));
    check("overrun",      32'(fifo_overrun),      32'(m_ovr));
    check("underrun",     32'(fifo_underrun),     32'(m_und));
    check("rd_data",      32'(rd_data),           32'(m_rd_data));
  endtask

  // One clock: drive inputs, take the edge, update the model, check #1 later.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                      input logic c = 1'b0, input logic rs = 1'b0);
    wr_enb  = w;
    rd_enb  = r;
    wr_data = d;
    err_clr = c;
    rst     = rs;
    @(posedge clk);
    model_edge(w, r, d, c, rs);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    // Fill, overrun, drain in order.
    do_reset();
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
    step(1'b1, 1'b0, 8'hFF);
    check("tp1_full",  32'(fifo_full),    32'd1);
    check("tp1_ovr",   32'(fifo_overrun), 32'd1);
    check("tp1_count", 32'(fifo_count),   32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0);
      check("tp1_order", 32'(rd_data), 32'(i));
    end

    // Underrun on empty, then software clear.
    do_reset();
    step(1'b0, 1'b1, '0);
    check("tp2_und",  32'(fifo_underrun), 32'd1);
    check("tp2_data", 32'(rd_data),       32'd0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("tp2_clr",  32'(fifo_underrun), 32'd0);

    // Set wins over a coincident clear.
    step(1'b0, 1'b1, '0, 1'b1);
    check("set_wins", 32'(fifo_underrun), 32'd1);

    // Almost-full threshold.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(8'h40 + i));
    step(1'b1, 1'b0, 8'hAA);
    check("tp3_af",    32'(fifo_almost_full), 32'd1);
    check("tp3_full",  32'(fifo_full),        32'd0);
    check("tp3_count", 32'(fifo_count),       32'd7);

    // Almost-empty after one read.
    do_reset();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h01);
    step(1'b0, 1'b1, '0);
    check("tp4_data", 32'(rd_data),           32'h00);
    check("tp4_ae",   32'(fifo_almost_empty), 32'd1);
    check("tp4_cnt",  32'(fifo_count),        32'd1);

    // Simultaneous read/write mid-fill, then drain.
    do_reset();
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    step(1'b1, 1'b1, 8'h55);
    check("tp5_data", 32'(rd_data),    32'h11);
    check("tp5_cnt",  32'(fifo_count), 32'd3);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    check("tp5_last", 32'(rd_data),    32'h55);

    // Empty with both requests: write taken, read rejected.
    do_reset();
    step(1'b1, 1'b1, 8'h77);
    check("empty_rw_cnt", 32'(fifo_count), 32'd1);

    // Full with both requests, wrap pairs, then reset mid-stream.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(8'h80 + i));
    step(1'b1, 1'b1, 8'h99);
    check("tp6_cnt", 32'(fifo_count),   32'd8);
    check("tp6_ovr", 32'(fifo_overrun), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, '0);
      step(1'b1, 1'b0, DW'(8'hC0 + i));
    end
    step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
    check("tp6_rst_cnt",   32'(fifo_count), 32'd0);
    check("tp6_rst_empty", 32'(fifo_empty), 32'd1);

    // Random traffic with write-heavy, read-heavy and balanced phases.
    for (int i = 0; i < 1500; i++) begin
      int pw, pr;
      case ((i / 150) % 3)
        0:       begin pw = 80; pr = 25; end
        1:       begin pw = 25; pr = 80; end
        default: begin pw = 50; pr = 50; end
      endcase
      step(1'($urandom_range(99) < pw), 1'($urandom_range(99) < pr),
           DW'($urandom), 1'($urandom_range(99) < 5), 1'($urandom_range(999) < 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
